sys_bus_arbiter: RTL and testbench

- Shares one downstream system-bus slave port (addr/wdata/wen/ren in, rdata/ack out) between N upstream system-bus masters, e.g. the AXI slave bridge, a DMA sequencer and a housekeeping sequencer.
- Captures each master's single-cycle wen/ren pulse into a per-master pending slot.
- Grants slots round-robin and issues exactly one downstream access at a time.
- Returns ack/rdata, or a timeout error, only to the owning master.

---
 rtl/sys_bus_arb_pkg.sv | 43 ++++
 rtl/sys_bus_arb_slot.sv | 51 +++++
 rtl/sys_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sys_bus_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_arb_pkg.sv
// Shared types and helpers for the system-bus arbiter.
// Slot payload widths are fixed here; the arbiter's AW/DW parameters default to them.
package sys_bus_arb_pkg;

  localparam int SBA_AW = 32;
  localparam int SBA_DW = 32;
  localparam int MAX_N  = 8;
  localparam int PTR_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              pending;
    logic              write;
    logic [SBA_AW-1:0] addr;
    logic [SBA_DW-1:0] wdata;
  } slot_t;

  // First pending index at or after ptr, wrapping modulo n (n <= MAX_N, ptr < n).
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_N-1:0] pend,
                                               input logic [PTR_W-1:0] ptr,
                                               input int               n);
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && pend[idx[PTR_W-1:0]]) begin
        pick  = idx[PTR_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sys_bus_arb_slot.sv
// One pending-request slot per upstream master: captures a strobe when empty
// (or being freed this cycle), flags a sticky overflow otherwise.
module sys_bus_arb_slot
  import sys_bus_arb_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [SBA_AW-1:0] addr_i,
  input  logic [SBA_DW-1:0] wdata_i,
  input  logic              wen_i,
  input  logic              ren_i,
  input  logic              free_i,
  output slot_t             slot_o,
  output logic              ovf_o
);

  slot_t slot_q, slot_d;
  logic  ovf_q, ovf_d;

  // Capture / release / overflow decision; write wins when both strobes are set.
  always_comb begin
    slot_d = slot_q;
    ovf_d  = ovf_q;
    if (free_i) slot_d.pending = 1'b0;
    if (wen_i || ren_i) begin
      if (!slot_q.pending || free_i) begin
        slot_d.pending = 1'b1;
        slot_d.write   = wen_i;
        slot_d.addr    = addr_i;
        slot_d.wdata   = wdata_i;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Slot and overflow registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      slot_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      ovf_q  <= ovf_d;
    end
  end

  assign slot_o = slot_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one downstream system-bus slave between N masters.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a pending slot; no grant in an m_ack cycle
//   ST_ISSUE | one-cycle s_wen/s_ren pulse for the granted slot
//   ST_WAIT  | holding address/data until s_ack or timeout
module sys_bus_arbiter
  import sys_bus_arb_pkg::*;
#(
  parameter int N   = 3,
  parameter int AW  = SBA_AW,
  parameter int DW  = SBA_DW,
  parameter int TMO = 128
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_wdata,
  input  logic [N-1:0]  m_wen,
  input  logic [N-1:0]  m_ren,
  output logic [DW-1:0] m_rdata,
  output logic [N-1:0]  m_ack,
  output logic [N-1:0]  m_err,
  output logic [N-1:0]  m_ovf,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_wen,
  output logic          s_ren,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack
);

  localparam int CW = $clog2(TMO);

  slot_t            slot_s [N];
  logic [N-1:0]     ovf_s;
  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] gnt_q, gnt_d, ptr_q, ptr_d, ptr_nxt, pick;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    s_addr_q, s_addr_d, pick_addr;
  logic [DW-1:0]    s_wdata_q, s_wdata_d, pick_wdata, m_rdata_q, m_rdata_d;
  logic [N-1:0]     m_ack_q, m_ack_d, m_err_q, m_err_d, gnt_oh;
  logic [MAX_N-1:0] pend;
  logic             pick_wr;

  // A slot is released in the cycle its m_ack is visible.
  for (genvar i = 0; i < N; i++) begin : g_slot
    sys_bus_arb_slot u_slot (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .addr_i  (m_addr[i*AW +: AW]),
      .wdata_i (m_wdata[i*DW +: DW]),
      .wen_i   (m_wen[i]),
      .ren_i   (m_ren[i]),
      .free_i  (m_ack_q[i]),
      .slot_o  (slot_s[i]),
      .ovf_o   (ovf_s[i])
    );
  end

  // Round-robin pick among pending slots and payload mux for the pick.
  always_comb begin
    pend = '0;
    for (int i = 0; i < N; i++) pend[i] = slot_s[i].pending;
    pick       = rr_pick(pend, ptr_q, N);
    pick_addr  = '0;
    pick_wdata = '0;
    pick_wr    = 1'b0;
    gnt_oh     = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == PTR_W'(i)) begin
        pick_addr  = slot_s[i].addr;
        pick_wdata = slot_s[i].wdata;
        pick_wr    = slot_s[i].write;
      end
      gnt_oh[i] = (gnt_q == PTR_W'(i));
    end
    ptr_nxt = (gnt_q == PTR_W'(N-1)) ? '0 : gnt_q + PTR_W'(1);
  end

  // Next-state and completion logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_ack_d   = '0;
    m_err_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if ((|pend) && !(|m_ack_q)) begin
          gnt_d     = pick;
          wr_d      = pick_wr;
          s_addr_d  = pick_addr;
          s_wdata_d = pick_wdata;
          cnt_d     = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (s_ack) begin
          m_ack_d   = gnt_oh;
          m_rdata_d = s_rdata;
          ptr_d     = ptr_nxt;
          state_d   = ST_IDLE;
        end else if (cnt_q == CW'(TMO-1)) begin
          m_ack_d   = gnt_oh;
          m_err_d   = gnt_oh;
          m_rdata_d = '0;
          ptr_d     = ptr_nxt;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_rdata_q <= m_rdata_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
    end
  end

  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wen   = (state_q == ST_ISSUE) && wr_q;
  assign s_ren   = (state_q == ST_ISSUE) && !wr_q;
  assign m_rdata = m_rdata_q;
  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign m_ovf   = ovf_s;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter (N=3, TMO=8).
module tb_sys_bus_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [95:0] m_addr, m_wdata;
  logic [2:0]  m_wen, m_ren;
  logic [31:0] m_rdata;
  logic [2:0]  m_ack, m_err, m_ovf;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_wen, s_ren, s_ack;

  int n_cmp = 0;
  int n_bad = 0;

  sys_bus_arbiter #(.N(3), .AW(32), .DW(32), .TMO(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_ren(m_ren),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .m_ovf(m_ovf),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen), .s_ren(s_ren),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got time-out expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    m_addr[i*32 +: 32]  = a;
    m_wdata[i*32 +: 32] = d;
    if (wr) m_wen[i] = 1'b1;
    else    m_ren[i] = 1'b1;
  endtask

  task automatic clr_req();
    m_wen = '0;
    m_ren = '0;
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_s_addr"},  s_addr, 32'h0);
    chk({tag, "_s_wdata"}, s_wdata, 32'h0);
    chk({tag, "_s_strb"},  32'({s_wen, s_ren}), 32'h0);
    chk({tag, "_m_ack"},   32'(m_ack), 32'h0);
    chk({tag, "_m_err"},   32'(m_err), 32'h0);
    chk({tag, "_m_ovf"},   32'(m_ovf), 32'h0);
    chk({tag, "_m_rdata"}, m_rdata, 32'h0);
  endtask

  // Wait for the next downstream access, check it, ack one cycle later, check the m_ack.
  task automatic serve(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] rd);
    logic       found;
    logic [2:0] oh;
    found = 1'b0;
    oh    = 3'b001 << idx;
    for (int c = 0; c < 20; c++) begin
      if (s_ren || s_wen) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      chk("serve_found", 32'h0, 32'h1);
      return;
    end
    chk("serve_addr", s_addr, a);
    chk("serve_type", 32'(s_wen), 32'(wr));
    tick();
    s_ack   = 1'b1;
    s_rdata = rd;
    tick();
    s_ack = 1'b0;
    chk("serve_ack", 32'(m_ack), 32'(oh));
    chk("serve_err", 32'(m_err), 32'h0);
    if (!wr) chk("serve_rdata", m_rdata, rd);
  endtask

  initial begin
    int pulses;
    ARESET  = 1'b1;
    m_addr  = '0;
    m_wdata = '0;
    m_wen   = '0;
    m_ren   = '0;
    s_rdata = '0;
    s_ack   = 1'b0;
    #3;
    check_idle_outs("reset");
    repeat (2) @(posedge ACLK);
    #3 ARESET = 1'b0;
    tick();
    tick();

    // Single write to master 1, slave acks in cycle 4.
    set_req(1, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
    tick();                                        // cycle 1
    clr_req();
    chk("wr_c1_swen", 32'(s_wen), 32'h0);
    tick();                                        // cycle 2
    chk("wr_c2_swen", 32'(s_wen), 32'h1);
    chk("wr_c2_sren", 32'(s_ren), 32'h0);
    chk("wr_c2_addr", s_addr, 32'h4000_0010);
    chk("wr_c2_data", s_wdata, 32'hDEAD_BEEF);
    tick();                                        // cycle 3
    chk("wr_c3_swen", 32'(s_wen), 32'h0);
    chk("wr_c3_addr", s_addr, 32'h4000_0010);
    tick();                                        // cycle 4
    s_ack = 1'b1;
    tick();                                        // cycle 5
    s_ack = 1'b0;
    chk("wr_c5_ack", 32'(m_ack), 32'h2);
    chk("wr_c5_err", 32'(m_err), 32'h0);
    tick();
    chk("wr_c6_ack", 32'(m_ack), 32'h0);
    tick();

    // Timeout on master 2: slave never acks, stale s_rdata must not leak.
    s_rdata = 32'hCAFE_F00D;
    set_req(2, 1'b0, 32'h2000_0020, 32'h0);
    tick();                                        // cycle 1
    clr_req();
    tick();                                        // cycle 2
    chk("tmo_c2_sren", 32'(s_ren), 32'h1);
    repeat (7) tick();                             // cycle 9
    chk("tmo_c9_ack", 32'(m_ack), 32'h0);
    tick();                                        // cycle 10
    chk("tmo_c10_ack", 32'(m_ack), 32'h4);
    chk("tmo_c10_err", 32'(m_err), 32'h4);
    chk("tmo_c10_rdata", m_rdata, 32'h0);
    tick();                                        // cycle 11: reuse slot 2
    chk("tmo_c11_ack", 32'(m_ack), 32'h0);
    set_req(2, 1'b0, 32'h2000_0024, 32'h0);
    tick();
    clr_req();
    serve(2, 1'b0, 32'h2000_0024, 32'h55AA_55AA);
    chk("tmo_reuse_ovf", 32'(m_ovf), 32'h0);
    tick();

    // Round robin, pointer at 0: two rounds of simultaneous reads.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, 32'h3000_0000 + 32'(r*16 + i*4), 32'h0);
      tick();
      clr_req();
      serve(0, 1'b0, 32'h3000_0000 + 32'(r*16),     (r == 0) ? 32'h1234_5678 : 32'h0BAD_F00D);
      serve(1, 1'b0, 32'h3000_0000 + 32'(r*16 + 4), 32'hA5A5_0001);
      serve(2, 1'b0, 32'h3000_0000 + 32'(r*16 + 8), 32'h5A5A_0002);
      tick();
    end

    // Overflow: second strobe on master 0 while its slot is still pending.
    set_req(0, 1'b0, 32'h5000_0000, 32'h0);
    tick();                                        // cycle 1
    clr_req();
    chk("ovf_c1", 32'(m_ovf), 32'h0);
    set_req(0, 1'b0, 32'h5000_0FF0, 32'h0);
    tick();                                        // cycle 2
    clr_req();
    chk("ovf_c2", 32'(m_ovf), 32'h1);
    serve(0, 1'b0, 32'h5000_0000, 32'h7777_0000);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_ren || s_wen || (m_ack != 3'b000)) pulses++;
    end
    chk("ovf_extra", 32'(pulses), 32'h0);
    chk("ovf_sticky", 32'(m_ovf), 32'h1);

    // Async reset during WAIT; a late s_ack must not produce an m_ack.
    set_req(1, 1'b0, 32'h6000_0000, 32'h0);
    tick();
    clr_req();
    tick();                                        // ISSUE
    chk("rst_issue_sren", 32'(s_ren), 32'h1);
    tick();                                        // WAIT
    tick();                                        // WAIT
    #2 ARESET = 1'b1;
    #1;
    check_idle_outs("rst_mid");
    #2 ARESET = 1'b0;
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (s_ren || s_wen || (m_ack != 3'b000) || (m_err != 3'b000)) pulses++;
      tick();
    end
    chk("rst_late_ack", 32'(pulses), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
